// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle controller: opcode and memory
// handshake in, datapath strobes and selects out.
interface multicycle_control_if;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
    logic [2:0] state;
    logic       done;
    logic       illegal;
    logic       timeout;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               state, done, illegal, timeout
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               state, done, illegal, timeout
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control FSM: FETCH/DECODE/EXEC/MEM/WB with a
// memory wait timeout and sticky illegal/timeout fault flags.
module multicycle_control #(
    parameter int TIMEOUT    = 16,
    parameter bit ENABLE_IMM = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_control_if.master  bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd7;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic [2:0]    state_q, state_d;
    logic [6:0]    opc_q;
    logic [CW-1:0] wait_q;
    logic          ill_q, tmo_q;
    logic          legal, mem_phase, tmo_hit;

    always_comb begin
        case (bus.opcode)
            OP_R, OP_LD, OP_SD, OP_BEQ: legal = 1'b1;
            OP_I:                       legal = ENABLE_IMM;
            default:                    legal = 1'b0;
        endcase
    end

    assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
    // mem_ready has priority: a ready on the last allowed wait cycle advances normally.
    assign tmo_hit   = (TIMEOUT > 0) && mem_phase && !bus.mem_ready && (wait_q == CNT_LAST);

    always_comb begin
        state_d = S_FAULT;
        case (state_q)
            S_FETCH:  state_d = bus.mem_ready ? S_DECODE : (tmo_hit ? S_FAULT : S_FETCH);
            S_DECODE: state_d = legal ? S_EXEC : S_FAULT;
            S_EXEC: begin
                case (opc_q)
                    OP_R:         state_d = S_WB;
                    OP_I:         state_d = ENABLE_IMM ? S_WB : S_FAULT;
                    OP_LD, OP_SD: state_d = S_MEM;
                    OP_BEQ:       state_d = S_FETCH;
                    default:      state_d = S_FAULT;
                endcase
            end
            S_MEM: begin
                if (bus.mem_ready)  state_d = (opc_q == OP_LD) ? S_WB : S_FETCH;
                else if (tmo_hit)   state_d = S_FAULT;
                else                state_d = S_MEM;
            end
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            opc_q   <= '0;
            wait_q  <= '0;
            ill_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) opc_q <= bus.opcode;
            // Any state change restarts the count, which covers entry to FETCH and MEM.
            if (state_d != state_q)
                wait_q <= '0;
            else if (mem_phase && !bus.mem_ready && wait_q != CNT_MAX)
                wait_q <= wait_q + 1'b1;
            ill_q <= ill_q | ((state_q == S_DECODE) && !legal);
            tmo_q <= tmo_q | tmo_hit;
        end
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.ir_write      = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.reg_write     = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 1'b0;
        bus.done          = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: bus.alu_src_b = 2'b10;
            S_EXEC: begin
                case (opc_q)
                    OP_R: begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_op    = 2'b10;
                    end
                    OP_I: begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_src_b = 2'b10;
                        bus.alu_op    = 2'b11;
                    end
                    OP_LD, OP_SD: begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_src_b = 2'b10;
                    end
                    OP_BEQ: begin
                        bus.alu_src_a     = 1'b1;
                        bus.alu_op        = 2'b01;
                        bus.pc_write_cond = 1'b1;
                        bus.pc_source     = 1'b1;
                        bus.done          = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                bus.iord = 1'b1;
                if (opc_q == OP_LD) bus.mem_read = 1'b1;
                if (opc_q == OP_SD) begin
                    bus.mem_write = 1'b1;
                    bus.done      = bus.mem_ready;
                end
            end
            S_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = (opc_q == OP_LD);
                bus.done       = 1'b1;
            end
            default: ;
        endcase
        // Reset may land in any state; keep every write strobe quiet while it is held.
        if (rst) begin
            bus.pc_write      = 1'b0;
            bus.pc_write_cond = 1'b0;
            bus.ir_write      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.reg_write     = 1'b0;
        end
    end

    assign bus.state   = state_q;
    assign bus.illegal = ill_q;
    assign bus.timeout = tmo_q;
endmodule
